essr_clear_ctrl: RTL and testbench

Service controller for a bank of `essr` mismatch flag cells. It watches each cell's `g`/`gn` pair and selects one raised flag at a time. It drives that cell's `r` input to clear the flag, confirms the flag returned to idle, and reports the outcome to a host over a valid/ready event channel.

---
 rtl/essr_clear_ctrl_if.sv | 24 ++
 rtl/essr_clear_ctrl.sv | 116 +++++++++++
 tb/tb_essr_clear_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/essr_clear_ctrl_if.sv
// essr_clear_ctrl_if: lane flag/clear signals and host event channel of the essr clear controller
interface essr_clear_ctrl_if #(
    parameter int N = 4
);
    logic [N-1:0] g;
    logic [N-1:0] gn;
    logic [N-1:0] r;
    logic         evt_valid;
    logic         evt_ready;
    logic [3:0]   evt_lane;
    logic [1:0]   evt_code;
    logic         busy;
    logic [15:0]  err_count;

    modport master (
        input  g, gn, evt_ready,
        output r, evt_valid, evt_lane, evt_code, busy, err_count
    );

    modport slave (
        output g, gn, evt_ready,
        input  r, evt_valid, evt_lane, evt_code, busy, err_count
    );
endinterface

// File: rtl/essr_clear_ctrl.sv
// essr_clear_ctrl: round-robin service of raised essr flags; optional error statistics under ESSR_CLR_STATS_EN
module essr_clear_ctrl #(
    parameter int N       = 4,
    parameter int HOLD    = 2,
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    essr_clear_ctrl_if.master bus
);
    localparam int LW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = $clog2(HOLD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [N-1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, PULSE, WAIT, REPORT} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_lane;
    logic [3:0]    r_last;
    logic [3:0]    w_pick;
    logic          w_found;
    logic          r_conf;
    logic [1:0]    r_code;
    logic [HW-1:0] r_hold;
    logic [TW-1:0] r_wcnt;
    logic          w_idle;
    logic          w_hs;

    assign w_idle = !bus.g[r_lane[LW-1:0]] && bus.gn[r_lane[LW-1:0]];
    assign w_hs   = bus.evt_valid && bus.evt_ready;

    // first raised lane after the last serviced one; lower offsets overwrite higher ones
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = N; k >= 1; k--) begin
            if (bus.g[LW'((int'(r_last) + k) % N)]) begin
                w_found = 1'b1;
                w_pick  = 4'((int'(r_last) + k) % N);
            end
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next-state decision
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_found ? PULSE : IDLE;
            PULSE:   w_next = (r_hold == HW'(HOLD - 1)) ? WAIT : PULSE;
            WAIT:    w_next = (w_idle || r_wcnt == TW'(TIMEOUT - 1)) ? REPORT : WAIT;
            REPORT:  w_next = w_hs ? IDLE : REPORT;
            default: w_next = IDLE;
        endcase
    end

    // lane capture, hold/wait counters, event code and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lane <= '0;
            r_last <= 4'(N - 1);
            r_conf <= 1'b0;
            r_code <= 2'b00;
            r_hold <= '0;
            r_wcnt <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_found) begin
                    r_lane <= w_pick;
                    r_conf <= bus.g[w_pick[LW-1:0]] && bus.gn[w_pick[LW-1:0]];
                    r_hold <= '0;
                    r_wcnt <= '0;
                end
                PULSE: r_hold <= r_hold + 1'b1;
                WAIT: if (w_idle) begin
                    r_code <= r_conf ? 2'b11 : 2'b01;
                end else begin
                    r_wcnt <= r_wcnt + 1'b1;
                    if (r_wcnt == TW'(TIMEOUT - 1)) r_code <= 2'b10;
                end
                REPORT: if (w_hs) r_last <= r_lane;
                default: ;
            endcase
        end
    end

    // outputs decoded from registered state only, so they move on clock edges
    always_comb begin
        bus.r         = (r_state == PULSE) ? (ONE << r_lane) : '0;
        bus.evt_valid = (r_state == REPORT);
        bus.evt_lane  = r_lane;
        bus.evt_code  = r_code;
        bus.busy      = (r_state != IDLE);
    end

`ifdef ESSR_CLR_STATS_EN
    logic [15:0] r_err;

    // saturating count of stuck and conflict events accepted by the host
    always_ff @(posedge clk) begin
        if (!rst_n)                                        r_err <= '0;
        else if (w_hs && r_code[1] && r_err != 16'hFFFF)   r_err <= r_err + 16'd1;
    end

    assign bus.err_count = r_err;
`else
    assign bus.err_count = 16'd0;
`endif
endmodule

// File: tb/tb_essr_clear_ctrl.sv
// tb_essr_clear_ctrl: random lane/host stimulus against a timestamp-based service model
module tb_essr_clear_ctrl;
    localparam int N       = 4;
    localparam int HOLD    = 2;
    localparam int TIMEOUT = 8;
    localparam int CYCLES  = 4000;

    logic clk = 1'b0;
    logic rst_n;

    essr_clear_ctrl_if #(.N(N)) bus ();

    essr_clear_ctrl #(.N(N), .HOLD(HOLD), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] gv, input int last);
        for (int k = 1; k <= N; k++) if (gv[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    // lane environment: 0 idle, 1 raised, 2 conflict (g&gn), 3 neither
    int       ls[N];
    bit       clr[N];
    int       cnt[N];
    int       dly[N];

    task automatic drive_lanes();
        for (int i = 0; i < N; i++) begin
            bus.g[i]  = (ls[i] == 1 || ls[i] == 2);
            bus.gn[i] = (ls[i] == 0 || ls[i] == 2);
        end
    endtask

    logic [N-1:0] g_prev, gn_prev;
    bit   svc, conf_e, hs, rst_new, rdy, exp_v, rst_app, was_idle;
    int   lane_e, s_start, ev_time, code_e, m_last, m_err, bp, exp_r, pulse_resets;

    initial begin
        rst_n = 1'b0;
        bus.evt_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            ls[i] = 1; clr[i] = 0; cnt[i] = 0; dly[i] = 0;
        end
        drive_lanes();
        g_prev = bus.g; gn_prev = bus.gn;
        svc = 0; m_last = N - 1; m_err = 0; hs = 0; bp = 0; pulse_resets = 0;
        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);
            rst_app  = !rst_n;
            was_idle = !svc;
            if (rst_app) begin
                svc = 0; m_last = N - 1; m_err = 0;
            end else if (svc && hs) begin
                svc = 0; m_last = lane_e;
`ifdef ESSR_CLR_STATS_EN
                if (code_e >= 2 && m_err < 65535) m_err++;
`endif
            end else if (was_idle && g_prev != 0) begin
                svc = 1; lane_e = rr_pick(g_prev, m_last);
                conf_e = g_prev[lane_e] && gn_prev[lane_e];
                s_start = cyc; ev_time = -1;
            end
            exp_r = (svc && cyc < s_start + HOLD) ? (1 << lane_e) : 0;
            exp_v = svc && ev_time >= 0 && cyc >= ev_time;
            check("r", int'(bus.r), exp_r);
            check("evt_valid", int'(bus.evt_valid), int'(exp_v));
            check("busy", int'(bus.busy), int'(svc));
            check("err_count", int'(bus.err_count), m_err);
            if (exp_v) begin
                check("evt_lane", int'(bus.evt_lane), lane_e);
                check("evt_code", int'(bus.evt_code), code_e);
            end
            for (int i = 0; i < N; i++) begin
                if (bus.r[i]) begin
                    clr[i] = 1; cnt[i] = 0;
                end else if (clr[i]) begin
                    if (cnt[i] >= dly[i]) begin
                        ls[i] = 0; clr[i] = 0;
                    end else begin
                        cnt[i]++;
                        if (cnt[i] == dly[i] && $urandom % 3 == 0) ls[i] = 3;
                    end
                end else if (ls[i] == 3) begin
                    ls[i] = 0;
                end else if (ls[i] == 0 && $urandom % 6 == 0) begin
                    ls[i]  = ($urandom % 3 == 0) ? 2 : 1;
                    dly[i] = ($urandom % 4 == 0) ? TIMEOUT + int'($urandom % 12) : int'($urandom % (TIMEOUT + 1));
                end else if (ls[i] == 0 && $urandom % 20 == 0) begin
                    ls[i] = 3;
                end
            end
            rst_new = 1;
            if (cyc < 2) rst_new = 0;
            else if (exp_r != 0 && $urandom % 6 == 0) begin rst_new = 0; pulse_resets++; end
            else if ($urandom % 400 == 0) rst_new = 0;
            if (bp > 0) begin rdy = 0; bp--; end
            else if ($urandom % 50 == 0) begin rdy = 0; bp = 20; end
            else rdy = $urandom % 2;
            rst_n = rst_new;
            bus.evt_ready = rdy;
            drive_lanes();
            if (svc && ev_time < 0 && cyc >= s_start + HOLD) begin
                if (!bus.g[lane_e] && bus.gn[lane_e]) begin
                    ev_time = cyc + 1; code_e = conf_e ? 3 : 1;
                end else if (cyc - (s_start + HOLD) + 1 == TIMEOUT) begin
                    ev_time = cyc + 1; code_e = 2;
                end
            end
            hs = exp_v && rdy && rst_new;
            g_prev = bus.g; gn_prev = bus.gn;
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
